seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clock cycles per digit slot; SHALL be at least 4.
REQ-002 Parameter GUARD, default 1000: cycles at the start of each slot with all anodes off; SHALL satisfy 1 <= GUARD < SCAN_DIV.
REQ-003 Parameter BLINK_FRAMES, default 125: frames per blink half-period; SHALL be at least 1.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 bcd_in  in  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-007 digit_en  in  4  per-digit enable; 1 means the digit may be displayed.
REQ-008 blink_en  in  4  per-digit blink request.
REQ-009 dp_en  in  4  per-digit decimal point request.
REQ-010 lzb_en  in  1  leading-zero blanking enable.
REQ-011 bcd_out  out  4  value of the current digit, fed to the shared bcdto7segment decoder.
REQ-012 anode  out  4  active-low digit drive; bit i drives digit i.
REQ-013 dp_n  out  1  active-low decimal point.
REQ-014 digit_sel  out  2  index of the current digit.
REQ-015 frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

Function
REQ-016 A slot counter SHALL count 0..SCAN_DIV-1 and wrap to 0; digit_sel SHALL increment when the counter wraps, sequencing 0,1,2,3,0.
REQ-017 A frame SHALL be 4 slots; frame_tick SHALL be 1 exactly when digit_sel==3 and counter==SCAN_DIV-1.
REQ-018 Shadow registers SHALL capture bcd_in, digit_en, blink_en, dp_en and lzb_en on every frame_tick cycle; the display SHALL use only shadow values, so input changes SHALL NOT be visible before the next frame starts.
REQ-019 Slot phase SHALL be GUARD while counter < GUARD and DRIVE otherwise; anode SHALL be 4'b1111 and dp_n SHALL be 1 throughout GUARD.
REQ-020 Digit i SHALL be visible iff: shadow digit_en[i]=1; the blink rule does not blank it; the LZB rule does not suppress it; and its value is <= 9.
REQ-021 Blink rule: blink_phase SHALL toggle after every BLINK_FRAMES frames (counted on frame_tick); digit i SHALL be blanked when blink_en[i]=1 and blink_phase=1.
REQ-022 LZB rule: when shadow lzb_en=1, digit i (i>=1) SHALL be suppressed if it and every higher digit are 0; digit 0 SHALL never be suppressed.
REQ-023 In DRIVE, anode SHALL be 0 only at bit digit_sel, and only if that digit is visible; otherwise anode SHALL be 4'b1111.
REQ-024 dp_n SHALL be 0 iff phase is DRIVE, the current digit is visible, and its shadow dp_en bit is 1.
REQ-025 bcd_out SHALL always equal the shadow value of digit digit_sel, regardless of visibility, including invalid values 10-15.
REQ-026 All outputs SHALL be combinational functions of registered state only; there SHALL be no combinational path from any input to any output.
REQ-027 At most one anode bit SHALL be 0 in any cycle.

Reset
REQ-028 When reset=1 at a clock edge, the following SHALL be cleared: counter, digit_sel, blink_phase, the blink frame count, and all shadow registers (all to 0).
REQ-029 In the cycle after reset, outputs SHALL be: anode=4'b1111, dp_n=1, bcd_out=0, digit_sel=0, frame_tick=0. The display SHALL stay dark until the first frame_tick loads the shadow registers.
REQ-030 Reset asserted mid-slot or mid-frame SHALL take priority over any other update in that cycle, including frame_tick capture.

Verification (SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2; cycle 0 = first cycle after reset deasserts)
REQ-031 Power-up scan:
- Stimulus: bcd_in=16'h1234, digit_en=4'hF, lzb_en=0.
- Response: anode=1111 for cycles 0-31; frame_tick at cycle 31; cycles 32-33 anode=1111; cycles 34-39 anode=1110 with bcd_out=4; cycles 42-47 anode=1101 with bcd_out=3.
REQ-032 Leading-zero blanking:
- Stimulus: bcd_in=16'h0050, lzb_en=1.
- Response: digits 3 and 2 stay dark; digit 1 shows 5; digit 0 shows 0.
- Stimulus: bcd_in=0.
- Response: only anode[0] is ever driven low.
REQ-033 Blink:
- Stimulus: blink_en=4'b0001.
- Response: digit 0 is driven for 2 frames, dark for 2 frames (64 cycles), and repeats; digits 1-3 are unaffected.
REQ-034 Tear-free update:
- Stimulus: change bcd_in from 16'h1234 to 16'h9876 at cycle 40.
- Response: bcd_out shows old digits until cycle 63; new values appear from cycle 64.
REQ-035 Invalid digit and decimal point:
- Stimulus: digit 2 = 4'hA, dp_en=4'b0010.
- Response: anode[2] stays 1 while bcd_out=A; dp_n=0 only in digit 1 DRIVE cycles.
REQ-036 Reset mid-operation:
- Stimulus: reset during a DRIVE cycle of digit 2.
- Response: next cycle anode=1111, digit_sel=0, frame_tick=0; display dark until the next frame_tick.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl - four-digit multiplexed 7-segment scan controller.
//
// This block scans four BCD digits onto a shared segment decoder. It
// inserts a guard interval with all anodes off at the start of every
// slot. It applies per-digit enable, blink, decimal point and
// leading-zero blanking. Inputs are captured into shadow registers once
// per frame, so a digit update can never tear across a frame.
//
// Ports
//   clk         in   clock; all state updates on the rising edge
//   reset       in   synchronous active-high reset
//   bcd_in      in   [15:0] four BCD digits, [3:0] is digit 0
//   digit_en    in   [3:0] per-digit display enable
//   blink_en    in   [3:0] per-digit blink request
//   dp_en       in   [3:0] per-digit decimal point request
//   lzb_en      in   leading-zero blanking enable
//   bcd_out     out  [3:0] shadow value of the current digit
//   anode       out  [3:0] active-low digit drive
//   dp_n        out  active-low decimal point
//   digit_sel   out  [1:0] index of the current digit
//   frame_tick  out  one-cycle pulse on the last cycle of each frame
//
// Slot phase (decoded from the slot counter)
//   state    | meaning
//   PH_GUARD | counter < GUARD, all anodes off, dp off
//   PH_DRIVE | current digit driven if visible
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  blink_en,
  input  logic [3:0]  dp_en,
  input  logic        lzb_en,
  output logic [3:0]  bcd_out,
  output logic [3:0]  anode,
  output logic        dp_n,
  output logic [1:0]  digit_sel,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_END  = CW'(GUARD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {PH_GUARD, PH_DRIVE} phase_t;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    sel_q;
  logic          blink_phase;
  logic [BW-1:0] blink_cnt;

  logic [15:0]   sh_bcd;
  logic [3:0]    sh_digit_en;
  logic [3:0]    sh_blink_en;
  logic [3:0]    sh_dp_en;
  logic          sh_lzb;

  logic          frame_end;
  phase_t        phase;
  logic [3:0]    digit_zero;
  logic [3:0]    suppress;
  logic [3:0]    visible;

  assign frame_end = (sel_q == 2'd3) && (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= '0;
      sel_q       <= '0;
      blink_phase <= 1'b0;
      blink_cnt   <= '0;
      sh_bcd      <= '0;
      sh_digit_en <= '0;
      sh_blink_en <= '0;
      sh_dp_en    <= '0;
      sh_lzb      <= 1'b0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        sel_q    <= sel_q + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end

      // Capture on the last cycle of the frame so the next frame starts
      // with a consistent set of digits.
      if (frame_end) begin
        sh_bcd      <= bcd_in;
        sh_digit_en <= digit_en;
        sh_blink_en <= blink_en;
        sh_dp_en    <= dp_en;
        sh_lzb      <= lzb_en;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    phase      = (slot_cnt < GUARD_END) ? PH_GUARD : PH_DRIVE;
    digit_zero = '0;
    suppress   = '0;
    visible    = '0;
    for (int i = 0; i < 4; i++) begin
      digit_zero[i] = (sh_bcd[4*i +: 4] == 4'd0);
    end
    // A digit is a leading zero only if it and every higher digit are zero.
    // Digit 0 always stays lit, so a value of 0 still shows "0".
    suppress[3] = sh_lzb && digit_zero[3];
    suppress[2] = suppress[3] && digit_zero[2];
    suppress[1] = suppress[2] && digit_zero[1];
    for (int i = 0; i < 4; i++) begin
      visible[i] = sh_digit_en[i]
                && !(sh_blink_en[i] && blink_phase)
                && !suppress[i]
                && (sh_bcd[4*i +: 4] <= 4'd9);
    end
  end

  always_comb begin
    anode      = 4'b1111;
    dp_n       = 1'b1;
    bcd_out    = sh_bcd[{sel_q, 2'b00} +: 4];
    digit_sel  = sel_q;
    frame_tick = frame_end;
    if (phase == PH_DRIVE && visible[sel_q]) begin
      anode[sel_q] = 1'b0;
      dp_n         = ~sh_dp_en[sel_q];
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BF = 2;

  logic        clk;
  logic        reset;
  logic [15:0] bcd_in;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic [3:0]  dp_en;
  logic        lzb_en;
  logic [3:0]  bcd_out;
  logic [3:0]  anode;
  logic        dp_n;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  seg_scan_ctrl #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .digit_en(digit_en),
    .blink_en(blink_en), .dp_en(dp_en), .lzb_en(lzb_en),
    .bcd_out(bcd_out), .anode(anode), .dp_n(dp_n),
    .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] anode;
    logic       dp_n;
    logic [3:0] bcd;
    logic [1:0] sel;
    logic       ft;
    string      name;
  } exp_t;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  en;
    logic [3:0]  blink;
    logic [3:0]  dp;
    logic        lzb;
    logic [15:0] anodes;  // expected drive-phase anode, digit d at [4d+:4]
    logic [3:0]  dpn;     // expected drive-phase dp_n per digit
    string       name;
  } vec_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic set_inputs(input logic [15:0] b, input logic [3:0] en,
                            input logic [3:0] bl, input logic [3:0] dp,
                            input logic lz);
    bcd_in = b; digit_en = en; blink_en = bl; dp_en = dp; lzb_en = lz;
  endtask

  task automatic push(input int c, input logic [3:0] a, input logic dn,
                      input logic [3:0] b, input logic [1:0] s,
                      input logic ft, input string nm);
    exp_t e;
    e.cyc = c; e.anode = a; e.dp_n = dn; e.bcd = b; e.sel = s; e.ft = ft;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Expected outputs for a frame where every digit of the given value is
  // enabled, no dp, no lzb; blank_d0 blanks digit 0 (blink phase 1).
  task automatic push_plain(input int c, input logic [15:0] val,
                            input bit blank_d0, input bit loaded,
                            input string nm);
    int d, off;
    logic [3:0] a;
    logic [3:0] b;
    d = (c / SD) % 4;
    off = c % SD;
    b = loaded ? val[4*d +: 4] : 4'h0;
    a = 4'b1111;
    if (loaded && off >= GD && !(d == 0 && blank_d0)) a[d] = 1'b0;
    push(c, a, 1'b1, b, 2'(d), (d == 3 && off == SD - 1), nm);
  endtask

  task automatic check(input exp_t e);
    n_checks++;
    if (anode === e.anode && dp_n === e.dp_n && bcd_out === e.bcd &&
        digit_sel === e.sel && frame_tick === e.ft) begin
      n_pass++;
    end else begin
      $display("FAIL %s cyc=%0d got anode=%b dp_n=%b bcd=%h sel=%0d ft=%b want anode=%b dp_n=%b bcd=%h sel=%0d ft=%b",
               e.name, cyc, anode, dp_n, bcd_out, digit_sel, frame_tick,
               e.anode, e.dp_n, e.bcd, e.sel, e.ft);
    end
  endtask

  task automatic run_sb();
    exp_t e;
    int start;
    start = cyc;
    while (sb.size() > 0) begin
      e = sb[0];
      if (cyc - start > 4000) begin
        n_checks++;
        $display("FAIL timeout cyc=%0d got pending=%0d want pending=0", cyc, sb.size());
        sb.delete();
      end else if (e.cyc < cyc) begin
        void'(sb.pop_front());
        n_checks++;
        $display("FAIL %s stale cyc=%0d got now=%0d want at=%0d", e.name, cyc, cyc, e.cyc);
      end else if (e.cyc == cyc) begin
        void'(sb.pop_front());
        check(e);
      end else begin
        tick();
      end
    end
  endtask

  vec_t vt[8];

  initial begin
    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    reset = 1'b1;
    set_inputs(16'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    vt[0] = '{16'h1234, 4'hF, 4'h0, 4'h0,    1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111, "plain"};
    vt[1] = '{16'h0050, 4'hF, 4'h0, 4'h0,    1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110}, 4'b1111, "lzb_0050"};
    vt[2] = '{16'h0000, 4'hF, 4'h0, 4'h0,    1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 4'b1111, "lzb_zero"};
    vt[3] = '{16'h0A21, 4'hF, 4'h0, 4'b0010, 1'b0, {4'b0111, 4'b1111, 4'b1101, 4'b1110}, 4'b1101, "invalid_dp"};
    vt[4] = '{16'h5678, 4'b0101, 4'h0, 4'hF, 1'b0, {4'b1111, 4'b1011, 4'b1111, 4'b1110}, 4'b1010, "digit_en"};
    vt[5] = '{16'h0102, 4'hF, 4'h0, 4'b1000, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110}, 4'b1111, "lzb_mid"};
    vt[6] = '{16'h1234, 4'hF, 4'hF, 4'b0001, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110}, 4'b1110, "blink_ph0"};
    vt[7] = '{16'h123F, 4'hF, 4'h0, 4'b0001, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1111}, 4'b1111, "invalid_d0"};

    // Table: inputs applied at cycle 0, captured at cycle 31, shown in frame 1.
    for (int k = 0; k < 8; k++) begin
      apply_reset();
      set_inputs(vt[k].bcd, vt[k].en, vt[k].blink, vt[k].dp, vt[k].lzb);
      push(0, 4'b1111, 1'b1, 4'h0, 2'd0, 1'b0, {vt[k].name, "_reset"});
      push(31, 4'b1111, 1'b1, 4'h0, 2'd3, 1'b1, {vt[k].name, "_predark"});
      for (int d = 0; d < 4; d++) begin
        int base;
        logic [3:0] bv;
        logic [3:0] av;
        base = 32 + SD * d;
        bv = vt[k].bcd[4*d +: 4];
        av = vt[k].anodes[4*d +: 4];
        push(base,          4'b1111, 1'b1,           bv, 2'(d), 1'b0, {vt[k].name, "_guard0"});
        push(base + GD - 1, 4'b1111, 1'b1,           bv, 2'(d), 1'b0, {vt[k].name, "_guard1"});
        push(base + GD,     av,      vt[k].dpn[d],   bv, 2'(d), 1'b0, {vt[k].name, "_drive0"});
        push(base + SD - 1, av,      vt[k].dpn[d],   bv, 2'(d), (d == 3), {vt[k].name, "_drivel"});
      end
      run_sb();
    end

    // Power-up: dark for the whole first frame, then scanning.
    apply_reset();
    set_inputs(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 48; c++) push_plain(c, 16'h1234, 1'b0, c >= 32, "powerup");
    run_sb();

    // Blink: digit 0 visible frame 1, dark frames 2-3, visible frames 4-5.
    apply_reset();
    set_inputs(16'h1234, 4'hF, 4'b0001, 4'h0, 1'b0);
    for (int c = 32; c < 192; c++) push_plain(c, 16'h1234, ((c / 32) / 2) % 2 == 1, 1'b1, "blink");
    run_sb();

    // Tear-free: change inputs mid-frame, new values only from cycle 64.
    apply_reset();
    set_inputs(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int c = 32; c < 40; c++) push_plain(c, 16'h1234, 1'b0, 1'b1, "tear_pre");
    run_sb();
    goto_cyc(40);
    bcd_in = 16'h9876;
    for (int c = 40; c < 72; c++) push_plain(c, (c < 64) ? 16'h1234 : 16'h9876, 1'b0, 1'b1, "tear");
    run_sb();

    // Reset during a digit-2 drive cycle.
    apply_reset();
    set_inputs(16'h1234, 4'hF, 4'h0, 4'b0100, 1'b0);
    push(51, 4'b1011, 1'b0, 4'h2, 2'd2, 1'b0, "pre_midreset");
    run_sb();
    goto_cyc(51);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    for (int c = 0; c < 32; c++) push_plain(c, 16'h1234, 1'b0, 1'b0, "midreset_dark");
    push(34, 4'b1110, 1'b1, 4'h4, 2'd0, 1'b0, "midreset_relit");
    run_sb();

    // Reset on the frame_tick cycle must win over the shadow capture.
    apply_reset();
    set_inputs(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
    goto_cyc(31);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc = 0;
    for (int c = 0; c < 32; c++) push_plain(c, 16'h1234, 1'b0, 1'b0, "ftreset_dark");
    for (int c = 32; c < 48; c++) push_plain(c, 16'h1234, 1'b0, 1'b1, "ftreset_relit");
    run_sb();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
